// File: rtl/weight_feeder.sv
// weight_feeder: unpacks 32-bit weight words into pixels for weight_fifo
// and replays each channel. Optional tlast check: WEIGHT_FEEDER_TLAST_CHECK_EN.
module weight_feeder #(
    parameter int PIX_WIDTH      = 8,
    parameter int SIZE_OF_WEIGHT = 5,
    parameter int N_OF_PIXELS    = SIZE_OF_WEIGHT * SIZE_OF_WEIGHT,
    parameter int BUS_WIDTH      = 32,
    parameter int LANES          = BUS_WIDTH / PIX_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [15:0]          i_num_channels,
    input  logic [7:0]           i_loop_count,
    input  logic [BUS_WIDTH-1:0] s_tdata,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    input  logic                 s_tlast,
    output logic                 o_wr_en,
    output logic [PIX_WIDTH-1:0] o_data,
    output logic                 o_rd_en,
    output logic                 o_loop_back,
    output logic                 o_flush,
    input  logic                 i_full,
    input  logic                 i_col_done,
    input  logic                 i_flush_fin,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);
    localparam int PCNT_W = $clog2(N_OF_PIXELS);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CCNT_W = (SIZE_OF_WEIGHT > 1) ? $clog2(SIZE_OF_WEIGHT) : 1;
    localparam logic [PCNT_W-1:0] LAST_PIX  = PCNT_W'(N_OF_PIXELS - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [CCNT_W-1:0] LAST_COL  = CCNT_W'(SIZE_OF_WEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_FLUSH,
        S_WAIT_FLUSH,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [BUS_WIDTH-1:0] r_hold;
    logic                 r_hold_full;
    logic [LANE_W-1:0]    r_lane;
    logic [PCNT_W-1:0]    r_pix_cnt;
    logic [CCNT_W-1:0]    r_col_cnt;
    logic [7:0]           r_pass_cnt;
    logic [7:0]           r_loops;
    logic [15:0]          r_ch_cnt;
    logic [15:0]          r_num_ch;

    logic w_accept;
    logic w_start;
    logic w_wr;
    logic w_pix_last;
    logic w_col_last;
    logic w_more_pass;
    logic w_ch_last;
    logic w_loop_back_nx;
    logic w_flush_nx;
    logic w_done_nx;

    assign s_tready    = (r_state == S_LOAD) && !r_hold_full;
    assign w_accept    = s_tready && s_tvalid;
    assign w_start     = (r_state == S_IDLE) && i_start;
    assign w_wr        = (r_state == S_LOAD) && r_hold_full && !i_full;
    assign w_pix_last  = (r_pix_cnt == LAST_PIX);
    assign w_col_last  = (r_state == S_RUN) && i_col_done
                         && (r_col_cnt == LAST_COL);
    assign w_more_pass = ({1'b0, r_pass_cnt} + 9'd1) < {1'b0, r_loops};
    assign w_ch_last   = (r_ch_cnt + 16'd1) == r_num_ch;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and next-cycle pulse outputs
    always_comb begin
        w_state_nx     = r_state;
        w_loop_back_nx = 1'b0;
        w_flush_nx     = 1'b0;
        w_done_nx      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nx = (i_num_channels == 16'd0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_wr && w_pix_last) begin
                    w_state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (w_col_last) begin
                    if (w_more_pass) begin
                        w_loop_back_nx = 1'b1;
                    end else begin
                        w_state_nx = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                w_flush_nx = 1'b1;
                w_state_nx = S_WAIT_FLUSH;
            end
            S_WAIT_FLUSH: begin
                if (i_flush_fin) begin
                    w_state_nx = w_ch_last ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                w_done_nx  = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Holding register, lane unpacking and channel/pass/column counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_lane      <= '0;
            r_pix_cnt   <= '0;
            r_col_cnt   <= '0;
            r_pass_cnt  <= '0;
            r_loops     <= 8'd1;
            r_ch_cnt    <= '0;
            r_num_ch    <= '0;
        end else begin
            if (w_start) begin
                r_num_ch    <= i_num_channels;
                r_loops     <= (i_loop_count == 8'd0) ? 8'd1 : i_loop_count;
                r_ch_cnt    <= '0;
                r_pix_cnt   <= '0;
                r_pass_cnt  <= '0;
                r_col_cnt   <= '0;
                r_hold_full <= 1'b0;
            end
            if (w_accept) begin
                r_hold      <= s_tdata;
                r_hold_full <= 1'b1;
                r_lane      <= '0;
            end
            if (w_wr) begin
                r_hold    <= r_hold >> PIX_WIDTH;
                r_lane    <= r_lane + 1'b1;
                r_pix_cnt <= w_pix_last ? '0 : r_pix_cnt + 1'b1;
                // Spare lanes of a channel's final word are dropped here
                if (w_pix_last || (r_lane == LAST_LANE)) begin
                    r_hold_full <= 1'b0;
                end
            end
            if ((r_state == S_RUN) && i_col_done) begin
                if (r_col_cnt == LAST_COL) begin
                    r_col_cnt  <= '0;
                    r_pass_cnt <= r_pass_cnt + 8'd1;
                end else begin
                    r_col_cnt <= r_col_cnt + 1'b1;
                end
            end
            if ((r_state == S_WAIT_FLUSH) && i_flush_fin) begin
                r_ch_cnt   <= r_ch_cnt + 16'd1;
                r_pass_cnt <= '0;
                r_col_cnt  <= '0;
            end
        end
    end

    // Registered FIFO-side and status outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wr_en     <= 1'b0;
            o_data      <= '0;
            o_rd_en     <= 1'b0;
            o_loop_back <= 1'b0;
            o_flush     <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_wr_en     <= w_wr;
            if (w_wr) begin
                o_data <= r_hold[PIX_WIDTH-1:0];
            end
            o_rd_en     <= (r_state == S_RUN);
            o_loop_back <= w_loop_back_nx;
            o_flush     <= w_flush_nx;
            o_busy      <= (w_state_nx != S_IDLE);
            o_done      <= w_done_nx;
        end
    end

`ifdef WEIGHT_FEEDER_TLAST_CHECK_EN
    logic w_last_word;
    assign w_last_word = (int'(r_pix_cnt) + LANES) >= N_OF_PIXELS;

    // Sticky flag for tlast not matching the channel's final word
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_err <= 1'b0;
        end else if (w_start) begin
            o_err <= 1'b0;
        end else if (w_accept && (s_tlast != w_last_word)) begin
            o_err <= 1'b1;
        end
    end
`else
    logic w_unused_tlast;
    assign w_unused_tlast = s_tlast;
    assign o_err          = 1'b0;
`endif

endmodule

// File: doc/weight_feeder.md
# weight_feeder

Upstream stage of `weight_fifo`. It accepts packed 32-bit weight words from the weight DMA stream and unpacks them into `PIX_WIDTH` pixels. It writes one `SIZE_OF_WEIGHT`² channel at a time into the FIFO, then drives `rd_en` and `loop_back` so the channel is replayed `i_loop_count` times. Between channels it runs the `i_flush`/`flush_fin` handshake before loading the next channel.

## Interface
- `PIX_WIDTH`, 8, bits per weight pixel.
- `SIZE_OF_WEIGHT`, 5, kernel side; one channel = `N_OF_PIXELS` pixels.
- `N_OF_PIXELS`, `SIZE_OF_WEIGHT*SIZE_OF_WEIGHT`, pixels per channel.
- `BUS_WIDTH`, 32, stream word width; `LANES = BUS_WIDTH/PIX_WIDTH` (4).
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  one-cycle start pulse; ignored unless in IDLE.
- `i_num_channels`  in  16  channels to process; latched on the accepted start.
- `i_loop_count`  in  8  passes per channel; latched on start; 0 is treated as 1.
- `s_tdata`  in  32  packed pixels; lane 0 = bits [7:0] is used first.
- `s_tvalid`  in  1  stream valid.
- `s_tready`  out  1  stream ready.
- `s_tlast`  in  1  last word of a channel; used only with `WEIGHT_FEEDER_TLAST_CHECK_EN`.
- `o_wr_en`  out  1  FIFO `wr_en`.
- `o_data`  out  `PIX_WIDTH`  FIFO `data_in`.
- `o_rd_en`  out  1  FIFO `rd_en`.
- `o_loop_back`  out  1  FIFO `loop_back`, one-cycle pulse.
- `o_flush`  out  1  FIFO `i_flush`, one-cycle pulse.
- `i_full`  in  1  FIFO `s_full`.
- `i_col_done`  in  1  FIFO `col_export_done`.
- `i_flush_fin`  in  1  FIFO `flush_fin`.
- `o_busy`  out  1  high in every state except IDLE.
- `o_done`  out  1  one-cycle pulse when all channels are finished.
- `o_err`  out  1  sticky tlast-misalignment flag; cleared by reset or an accepted start.

## Operation
- States: IDLE, LOAD, RUN, FLUSH, WAIT_FLUSH, DONE.
- **IDLE**
  - `i_start` → LOAD; clears channel count, pixel count and pass count.
  - If `i_num_channels == 0`, go directly to DONE instead.
- **LOAD**
  - 32-bit holding register plus a lane index.
  - `s_tready = (state == LOAD) && holding_empty`.
  - Each cycle the holding register is full and `!i_full`, the current lane is written (`o_wr_en = 1`, `o_data = lane`).
  - After the last lane of a word, or after pixel `N_OF_PIXELS-1`, the holding register is marked empty.
  - A channel uses ceil(25/4) = 7 words. Unused lanes of the 7th word (lanes 1–3) are discarded; a new channel always starts on a word boundary.
  - After pixel 24 is written → RUN.
- **RUN**
  - `o_rd_en = 1`.
  - Count `i_col_done` pulses. On the `SIZE_OF_WEIGHT`-th pulse, increment the pass count.
  - If pass < loop count: pulse `o_loop_back`, clear the column count, stay in RUN.
  - Otherwise → FLUSH.
- **FLUSH**: `o_flush = 1` for one cycle → WAIT_FLUSH.
- **WAIT_FLUSH**
  - On `i_flush_fin`, increment the channel count.
  - Channel count == `i_num_channels` → DONE; otherwise → LOAD.
- **DONE**: `o_done = 1` for one cycle → IDLE.
- Counters: pixel count 0..24 (5 bits); channel count 16 bits; pass count 8 bits. No wrap is possible because the limits are latched.

## Timing
- All outputs are registered except `s_tready`, which is combinational from state and `holding_empty`.
- Reset values: every output is 0, state is IDLE.
- Reset is honoured mid-operation in any state. Partial channel data is abandoned; the FIFO must be flushed by its own reset.
- **Word handshake**
  - A word is accepted on `s_tvalid && s_tready`. Its first pixel write happens the next cycle.
  - Sustained throughput is 4 pixels per 5 cycles: one bubble per word while the register refills.
- **Full backpressure**: `i_full` high stalls writes. The pixel and lane are held, and resume on the first cycle `i_full` is low.
- **Simultaneous events**
  - `i_start` outside IDLE is ignored.
  - `i_col_done` arriving in the same cycle an `o_loop_back` is issued counts toward the new pass.
- **Wait states**: `i_flush_fin` is ignored outside WAIT_FLUSH. WAIT_FLUSH waits indefinitely; there is no timeout.

## Configuration
- `WEIGHT_FEEDER_TLAST_CHECK_EN`
  - **Defined:** `s_tlast` is sampled on each accepted word. `o_err` is set if `tlast` is high on any word other than the 7th of a channel, or low on the 7th. Data is still used unchanged.
  - **Undefined:** `s_tlast` is ignored and `o_err` is tied to 0.

## Test plan
- Start with 1 channel, loop 1; 7 words carrying pixels 0x01..0x19 with lanes 1–3 of word 7 = 0xFF → 25 writes in order 0x01..0x19, no 0xFF written; 5 `i_col_done` → `o_flush` → `i_flush_fin` → `o_done`.
- Loop 3 → exactly 2 `o_loop_back` pulses, each following the 5th `i_col_done` of a pass; then one `o_flush`.
- Hold `i_full` high for 10 cycles after pixel 12 → no writes during the stall; pixel 13 is written on the first low cycle; total of 25 writes.
- `i_num_channels = 0` → `o_done` pulses within 2 cycles of start; `s_tready` never rises.
- Reset pulsed during LOAD after 9 writes, then a fresh start with 2 channels → writes restart at the channel's first pixel; `o_done` only after 2 flush handshakes.
- With `WEIGHT_FEEDER_TLAST_CHECK_EN`: `tlast` on word 6 → `o_err = 1` and stays set until the next start; correct `tlast` on word 7 → `o_err = 0`.
